bf16_simd_sequencer: RTL and testbench
======================================

// Module: bf16_simd_sequencer
// PURPOSE
//   Time-multiplexes one shared BF16 FMA pipeline across the SIMD lanes of a packed instruction.
//   Accepts one request on a valid/ready handshake and maps funct5 onto FMA operands
//   (add/sub as a*1.0+c, mul as a*b+0, fma variants as a*b+c). Issues one lane per cycle,
//   collects results after the fixed FMA latency and returns one packed response.
//   Sits between the instruction issue stage and the BF16 FMA unit.
// PARAMETERS
//   LANES    2  number of 16-bit BF16 lanes per packed operand (>=1)
//   FMA_LAT  3  FMA pipeline latency in cycles, issue to result (>=1)
// PORTS
//   clk          in   1         clock, rising edge
//   rst_n        in   1         asynchronous active-low reset
//   req_valid    in   1         request present
//   req_ready    out  1         block can accept a request (high only in IDLE)
//   req_funct5   in   5         operation code
//   req_rs1      in   16*LANES  packed operand 1; lane i = bits [16i+15:16i]
//   req_rs2      in   16*LANES  packed operand 2
//   req_rs3      in   16*LANES  packed operand 3
//   fma_valid    out  1         lane operands on fma_a/b/c are valid this cycle
//   fma_funct5   out  5         latched funct5 forwarded to the FMA (sign/negate control)
//   fma_a        out  16        FMA multiplicand
//   fma_b        out  16        FMA multiplier
//   fma_c        out  16        FMA addend
//   fma_res      in   16        FMA result; valid FMA_LAT cycles after the matching fma_valid
//   rsp_valid    out  1         packed response present
//   rsp_ready    in   1         consumer accepts response
//   rsp_data     out  16*LANES  packed results, lane order as request
//   rsp_illegal  out  1         funct5 unsupported; rsp_data all zero
//   busy         out  1         high in every state except IDLE
// BEHAVIOUR
//   Reset: async on rst_n low. State=IDLE, lane counter=0, in-flight tag shift register cleared.
//     All outputs 0 except req_ready=1. Results returning from the FMA after reset are ignored.
//   Operand map per lane i (x = rs1/2/3 lane i):
//     00000, 00001   a=rs1, b=16'h3F80 (1.0), c=rs2
//     00010          a=rs1, b=rs2, c=16'h0000
//     00100, 00101   a=rs1, b=rs2, c=rs3
//     any other      illegal; no FMA issue
//   fma_a/b/c/funct5 drive 0 whenever fma_valid=0.
//   FSM:
//     IDLE   req_ready=1. On req_valid, latch funct5 and operands.
//            Legal funct5 -> ISSUE with lane=0. Illegal -> RESP with rsp_illegal=1 and rsp_data=0.
//     ISSUE  fma_valid=1 every cycle, lane 0 first; lane increments each cycle.
//            After lane LANES-1 -> DRAIN. Issue is never stalled.
//     DRAIN  Wait for outstanding results. When the last result is captured -> RESP.
//     RESP   rsp_valid=1; rsp_data and rsp_illegal held stable. On rsp_ready -> IDLE.
//   Result capture:
//     A tag shift register of depth FMA_LAT carries {valid, lane index} from each issue.
//     When the tag exits with valid=1, fma_res is written to that lane slot of rsp_data.
//     Capture is active in ISSUE and DRAIN; with LANES > FMA_LAT it overlaps ISSUE.
//   Latency: let T be the request-accept cycle.
//     Lanes issue in cycles T+1 .. T+LANES.
//     The last result is sampled in cycle T+LANES+FMA_LAT.
//     rsp_valid rises at T+LANES+FMA_LAT+1 (T+6 at defaults).
//     Illegal requests: rsp_valid rises at T+1.
//   One request in flight at a time. req_ready=0 from the accept edge until the RESP handshake completes.
//     The next request can be accepted no earlier than the cycle after rsp_valid & rsp_ready.
//   rsp_valid=1 with rsp_ready=0: the response holds indefinitely; nothing else changes.
//   rsp_data slots are cleared when a request is accepted; no stale lanes leak between requests.
//   Reset asserted mid-operation aborts immediately: no response is produced and tags are discarded.
// TESTING
//   Bench uses a behavioural FMA model with latency FMA_LAT.
//   funct5=00000, rs1={3F80,4000}, rs2={3F80,3F80} -> rsp_data={4000,4040} at T+6; rsp_illegal=0.
//   funct5=00010, rs1={4040,4000}, rs2={4000,4000} -> fma_b=rs2 lanes, fma_c=0; rsp_data={40C0,4080}.
//   funct5=00011 -> no fma_valid pulse; rsp_valid at T+1; rsp_data=0; rsp_illegal=1.
//   Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data stable; req_ready=0; busy=1; then release -> IDLE.
//   Assert rst_n low during ISSUE lane 1 -> outputs at reset values; late fma_res ignored;
//     next request returns correct data.
//   Back-to-back requests with rsp_ready tied high, LANES=4, FMA_LAT=2 -> capture overlaps issue;
//     each rsp at T+7; no lane corruption.

Source files
------------

// File: rtl/bf16_simd_sequencer.sv
// bf16_simd_sequencer: shares one BF16 FMA pipeline across the lanes of a
// packed SIMD request. It issues one lane per cycle, tracks in-flight lanes
// with a tag shift register and assembles a single packed response.
module bf16_simd_sequencer #(
  parameter int LANES   = 2,
  parameter int FMA_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_funct5,
  input  logic [16*LANES-1:0]   req_rs1,
  input  logic [16*LANES-1:0]   req_rs2,
  input  logic [16*LANES-1:0]   req_rs3,
  output logic                  fma_valid,
  output logic [4:0]            fma_funct5,
  output logic [15:0]           fma_a,
  output logic [15:0]           fma_b,
  output logic [15:0]           fma_c,
  input  logic [15:0]           fma_res,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [16*LANES-1:0]   rsp_data,
  output logic                  rsp_illegal,
  output logic                  busy
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t               r_state;
  logic [LW-1:0]        r_lane;
  logic                 r_illegal;
  logic [16*LANES-1:0]  r_rsp_data;
  logic [4:0]           r_funct5;
  logic [16*LANES-1:0]  r_rs1;
  logic [16*LANES-1:0]  r_rs2;
  logic [16*LANES-1:0]  r_rs3;
  logic [FMA_LAT-1:0]   r_tag_vld;
  logic [LW-1:0]        r_tag_lane [FMA_LAT];

  logic                 w_accept;
  logic                 w_legal;
  logic                 w_issue;
  logic                 w_cap;
  logic [LW-1:0]        w_cap_lane;
  logic [47:0]          w_ops;

  function automatic logic is_legal(input logic [4:0] f5);
    case (f5)
      5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b00101: is_legal = 1'b1;
      default:                                           is_legal = 1'b0;
    endcase
  endfunction

  // Returns {a, b, c}: add/sub use b=1.0, mul uses c=0, fma passes all three.
  function automatic logic [47:0] map_ops(input logic [4:0] f5, input logic [15:0] x1,
                                          input logic [15:0] x2, input logic [15:0] x3);
    case (f5)
      5'b00000, 5'b00001: map_ops = {x1, 16'h3F80, x2};
      5'b00010:           map_ops = {x1, x2, 16'h0000};
      5'b00100, 5'b00101: map_ops = {x1, x2, x3};
      default:            map_ops = 48'h0;
    endcase
  endfunction

  assign w_accept   = (r_state == IDLE) && req_valid;
  assign w_legal    = is_legal(req_funct5);
  assign w_issue    = (r_state == ISSUE);
  assign w_cap_lane = r_tag_lane[FMA_LAT-1];
  assign w_cap      = r_tag_vld[FMA_LAT-1] && ((r_state == ISSUE) || (r_state == DRAIN));
  assign w_ops      = map_ops(r_funct5, r_rs1[{r_lane, 4'b0000} +: 16],
                              r_rs2[{r_lane, 4'b0000} +: 16], r_rs3[{r_lane, 4'b0000} +: 16]);

  assign req_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign fma_valid   = w_issue;
  assign fma_funct5  = w_issue ? r_funct5 : 5'd0;
  assign fma_a       = w_issue ? w_ops[47:32] : 16'h0;
  assign fma_b       = w_issue ? w_ops[31:16] : 16'h0;
  assign fma_c       = w_issue ? w_ops[15:0]  : 16'h0;
  assign rsp_valid   = (r_state == RESP);
  assign rsp_data    = r_rsp_data;
  assign rsp_illegal = r_illegal;

  // Sequencer FSM plus response assembly from returning FMA results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lane     <= '0;
      r_illegal  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_rsp_data <= '0;
            r_lane     <= '0;
            r_illegal  <= !w_legal;
            r_state    <= w_legal ? ISSUE : RESP;
          end
        end
        ISSUE: begin
          r_lane <= r_lane + 1'b1;
          if (r_lane == LAST) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_cap && (w_cap_lane == LAST)) r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state   <= IDLE;
            r_illegal <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_cap) r_rsp_data[{w_cap_lane, 4'b0000} +: 16] <= fma_res;
    end
  end

  // Tag valid bits: one per FMA pipeline slot, cleared on reset so late results are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld[0] <= w_issue;
      for (int i = 1; i < FMA_LAT; i++) r_tag_vld[i] <= r_tag_vld[i-1];
    end
  end

  // Tag lane indices and latched request payload; qualified by the valid bits / state.
  always_ff @(posedge clk) begin
    r_tag_lane[0] <= r_lane;
    for (int i = 1; i < FMA_LAT; i++) r_tag_lane[i] <= r_tag_lane[i-1];
    if (w_accept) begin
      r_funct5 <= req_funct5;
      r_rs1    <= req_rs1;
      r_rs2    <= req_rs2;
      r_rs3    <= req_rs3;
    end
  end

endmodule

// File: tb/tb_bf16_simd_sequencer.sv
// Directed bench for bf16_simd_sequencer: a default instance (2 lanes, latency 3)
// and a 4-lane / latency-2 instance, each fed by a behavioural BF16 FMA model.
module tb_bf16_simd_sequencer;

  localparam int L1 = 2, T1 = 3;
  localparam int L2 = 4, T2 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance 1 signals
  logic            req_valid = 1'b0, req_ready;
  logic [4:0]      req_funct5 = 5'd0;
  logic [16*L1-1:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
  logic            fma_valid;
  logic [4:0]      fma_funct5;
  logic [15:0]     fma_a, fma_b, fma_c, fma_res;
  logic            rsp_valid, rsp_ready = 1'b0, rsp_illegal, busy;
  logic [16*L1-1:0] rsp_data;

  // Instance 2 signals
  logic            req_valid2 = 1'b0, req_ready2;
  logic [4:0]      req_funct52 = 5'd0;
  logic [16*L2-1:0] req_rs12 = '0, req_rs22 = '0, req_rs32 = '0;
  logic            fma_valid2;
  logic [4:0]      fma_funct52;
  logic [15:0]     fma_a2, fma_b2, fma_c2, fma_res2;
  logic            rsp_valid2, rsp_illegal2, busy2;
  logic [16*L2-1:0] rsp_data2;

  bf16_simd_sequencer #(.LANES(L1), .FMA_LAT(T1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct5(req_funct5),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .fma_valid(fma_valid), .fma_funct5(fma_funct5),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_res(fma_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_illegal(rsp_illegal), .busy(busy)
  );

  bf16_simd_sequencer #(.LANES(L2), .FMA_LAT(T2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_funct5(req_funct52),
    .req_rs1(req_rs12), .req_rs2(req_rs22), .req_rs3(req_rs32),
    .fma_valid(fma_valid2), .fma_funct5(fma_funct52),
    .fma_a(fma_a2), .fma_b(fma_b2), .fma_c(fma_c2), .fma_res(fma_res2),
    .rsp_valid(rsp_valid2), .rsp_ready(1'b1), .rsp_data(rsp_data2),
    .rsp_illegal(rsp_illegal2), .busy(busy2)
  );

  // Behavioural BF16 arithmetic via double precision (normal values only).
  function automatic real bf2r(input logic [15:0] h);
    logic [10:0] e;
    if (h[14:7] == 8'd0) return 0.0;
    e = {3'b000, h[14:7]} - 11'd127 + 11'd1023;
    return $bitstoreal({h[15], e, h[6:0], 45'd0});
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 16'h0000;
    b = $realtobits(r);
    e = b[62:52] - 11'd1023 + 11'd127;
    return {b[63], e[7:0], b[51:45]};
  endfunction

  function automatic logic [15:0] fma_model(input logic [4:0] f, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] c);
    real ra, rb, rc, r;
    ra = bf2r(a); rb = bf2r(b); rc = bf2r(c);
    case (f)
      5'd1:    r = ra * rb - rc;
      5'd5:    r = rc - ra * rb;
      default: r = ra * rb + rc;
    endcase
    return r2bf(r);
  endfunction

  logic [15:0] m1 [T1];
  logic [15:0] m2 [T2];
  always @(posedge clk) begin
    m1[0] <= fma_valid ? fma_model(fma_funct5, fma_a, fma_b, fma_c) : 16'hDEAD;
    for (int i = 1; i < T1; i++) m1[i] <= m1[i-1];
    m2[0] <= fma_valid2 ? fma_model(fma_funct52, fma_a2, fma_b2, fma_c2) : 16'hDEAD;
    for (int i = 1; i < T2; i++) m2[i] <= m2[i-1];
  end
  assign fma_res  = m1[T1-1];
  assign fma_res2 = m2[T2-1];

  // Present one request to instance 1; it is accepted at the next rising edge (cycle T).
  task automatic send1(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    @(negedge clk);
    req_valid = 1'b1; req_funct5 = f; req_rs1 = a; req_rs2 = b; req_rs3 = c;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Complete the response handshake and return to the sampling phase.
  task automatic finish1();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b want=1", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (rsp_valid !== 1'b0 || rsp_illegal !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%0b/%0b want=0/0", rsp_valid, rsp_illegal); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
    total++; if (fma_valid !== 1'b0 || fma_a !== 16'h0 || fma_funct5 !== 5'd0) begin bad++; $display("FAIL reset_fma got=%0b %h %0d want=0 0 0", fma_valid, fma_a, fma_funct5); end
    total++; if (req_ready2 !== 1'b1 || busy2 !== 1'b0) begin bad++; $display("FAIL reset_dut2 got=%0b/%0b want=1/0", req_ready2, busy2); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [15:0] ea [2];
    int n_iss, first;
    ea = '{16'h4000, 16'h3F80};
    n_iss = 0; first = 0;
    send1(5'b00000, 32'h3F80_4000, 32'h3F80_3F80, 32'h1234_5678);
    for (int k = 1; k <= 12 && first == 0; k++) begin
      @(negedge clk);
      if (fma_valid) begin
        if (n_iss < 2) begin
          total++;
          if (fma_a !== ea[n_iss] || fma_b !== 16'h3F80 || fma_c !== 16'h3F80) begin
            bad++; $display("FAIL add_ops lane%0d got=%h,%h,%h want=%h,3f80,3f80", n_iss, fma_a, fma_b, fma_c, ea[n_iss]);
          end
        end
        n_iss++;
      end
      if (k == 3) begin
        total++; if (fma_a !== 16'h0 || fma_c !== 16'h0 || busy !== 1'b1) begin bad++; $display("FAIL add_drain_idle_ops got=%h %h busy=%0b want=0 0 1", fma_a, fma_c, busy); end
      end
      if (rsp_valid) first = k;
    end
    total++; if (first != 6) begin bad++; $display("FAIL add_latency got=%0d want=6", first); end
    total++; if (n_iss != 2) begin bad++; $display("FAIL add_issue_count got=%0d want=2", n_iss); end
    total++; if (rsp_data !== 32'h4000_4040 || rsp_illegal !== 1'b0) begin bad++; $display("FAIL add_data got=%h ill=%0b want=40004040 ill=0", rsp_data, rsp_illegal); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL add_req_ready_resp got=%0b want=0", req_ready); end
    finish1();
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL add_back_idle got=%0b/%0b want=1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_mul();
    logic [15:0] ea [2];
    int n_iss, first;
    ea = '{16'h4000, 16'h4040};
    n_iss = 0; first = 0;
    send1(5'b00010, 32'h4040_4000, 32'h4000_4000, 32'h3F80_3F80);
    for (int k = 1; k <= 12 && first == 0; k++) begin
      @(negedge clk);
      if (fma_valid) begin
        if (n_iss < 2) begin
          total++;
          if (fma_a !== ea[n_iss] || fma_b !== 16'h4000 || fma_c !== 16'h0000 || fma_funct5 !== 5'b00010) begin
            bad++; $display("FAIL mul_ops lane%0d got=%h,%h,%h f=%0d want=%h,4000,0000 f=2", n_iss, fma_a, fma_b, fma_c, fma_funct5, ea[n_iss]);
          end
        end
        n_iss++;
      end
      if (rsp_valid) first = k;
    end
    total++; if (first != 6) begin bad++; $display("FAIL mul_latency got=%0d want=6", first); end
    total++; if (rsp_data !== 32'h40C0_4080) begin bad++; $display("FAIL mul_data got=%h want=40c04080", rsp_data); end
    finish1();
  endtask

  task automatic test_fma();
    int first;
    first = 0;
    send1(5'b00100, 32'h4000_4000, 32'h4000_3F80, 32'h3F80_4000);
    for (int k = 1; k <= 12 && first == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++; if (fma_c !== 16'h4000) begin bad++; $display("FAIL fma_c_lane0 got=%h want=4000", fma_c); end
      end
      if (rsp_valid) first = k;
    end
    total++; if (first != 6 || rsp_data !== 32'h40A0_4080) begin bad++; $display("FAIL fma_data got=%h at %0d want=40a04080 at 6", rsp_data, first); end
    finish1();
  endtask

  task automatic test_illegal();
    int n_iss, first;
    n_iss = 0; first = 0;
    send1(5'b00011, 32'h4000_4000, 32'h4000_4000, 32'h4000_4000);
    for (int k = 1; k <= 8 && first == 0; k++) begin
      @(negedge clk);
      if (fma_valid) n_iss++;
      if (rsp_valid) first = k;
    end
    total++; if (first != 1) begin bad++; $display("FAIL illegal_latency got=%0d want=1", first); end
    total++; if (n_iss != 0) begin bad++; $display("FAIL illegal_issue got=%0d want=0", n_iss); end
    total++; if (rsp_data !== 32'h0 || rsp_illegal !== 1'b1) begin bad++; $display("FAIL illegal_rsp got=%h ill=%0b want=0 ill=1", rsp_data, rsp_illegal); end
    finish1();
    total++; if (req_ready !== 1'b1 || rsp_illegal !== 1'b0) begin bad++; $display("FAIL illegal_idle got=%0b ill=%0b want=1 ill=0", req_ready, rsp_illegal); end
  endtask

  task automatic test_hold();
    int first;
    first = 0;
    send1(5'b00000, 32'h3F80_4000, 32'h3F80_3F80, 32'h0);
    for (int k = 1; k <= 12 && first == 0; k++) begin
      @(negedge clk);
      if (rsp_valid) first = k;
    end
    total++; if (first != 6) begin bad++; $display("FAIL hold_latency got=%0d want=6", first); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h4000_4040 || req_ready !== 1'b0 || busy !== 1'b1 || fma_valid !== 1'b0) begin
        bad++; $display("FAIL hold_cycle%0d got=v%0b d=%h rdy=%0b busy=%0b want=v1 d=40004040 rdy=0 busy=1", k, rsp_valid, rsp_data, req_ready, busy);
      end
    end
    finish1();
    total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL hold_release got=%0b/%0b want=1/0", req_ready, busy); end
  endtask

  task automatic test_midreset();
    int first;
    first = 0;
    send1(5'b00100, 32'h4000_4000, 32'h4000_3F80, 32'h3F80_4000);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (fma_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
      bad++; $display("FAIL midreset_outputs got=fv%0b rdy%0b busy%0b rv%0b d=%h want=0 1 0 0 0", fma_valid, req_ready, busy, rsp_valid, rsp_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid || !req_ready || rsp_data !== 32'h0) begin
        total++; bad++; $display("FAIL midreset_late_result cyc%0d got=rv%0b rdy%0b d=%h want=0 1 0", k, rsp_valid, req_ready, rsp_data);
      end
    end
    total++;
    send1(5'b00010, 32'h4040_4000, 32'h4000_4000, 32'h0);
    for (int k = 1; k <= 12 && first == 0; k++) begin
      @(negedge clk);
      if (rsp_valid) first = k;
    end
    if (first != 6 || rsp_data !== 32'h40C0_4080) begin bad++; $display("FAIL midreset_next got=%h at %0d want=40c04080 at 6", rsp_data, first); end
    finish1();
  endtask

  task automatic test_back_to_back();
    int n_rsp, n_iss;
    int rk [2];
    logic [63:0] rd [2];
    n_rsp = 0; n_iss = 0; rk = '{0, 0}; rd = '{64'h0, 64'h0};
    @(negedge clk);
    req_valid2 = 1'b1; req_funct52 = 5'b00010;
    req_rs12 = 64'h4000_4040_3F80_4000; req_rs22 = 64'h4000_4000_4000_4000; req_rs32 = '0;
    @(posedge clk);
    #1 req_funct52 = 5'b00000;
    req_rs12 = 64'h3F80_3F80_4000_4040; req_rs22 = 64'h3F80_4000_3F80_4000;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (fma_valid2) n_iss++;
      if (rsp_valid2 && n_rsp < 2) begin rk[n_rsp] = k; rd[n_rsp] = rsp_data2; n_rsp++; end
      if (k == 8) begin
        total++; if (req_ready2 !== 1'b1 || busy2 !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%0b/%0b want=1/0", req_ready2, busy2); end
      end
      if (k == 15) req_valid2 = 1'b0;
    end
    total++; if (rk[0] != 7 || rd[0] !== 64'h4080_40C0_4000_4080) begin bad++; $display("FAIL b2b_rsp0 got=%h at %0d want=408040c040004080 at 7", rd[0], rk[0]); end
    total++; if (rk[1] != 15 || rd[1] !== 64'h4000_4040_4040_40A0) begin bad++; $display("FAIL b2b_rsp1 got=%h at %0d want=400040404040 40a0 at 15", rd[1], rk[1]); end
    total++; if (n_iss != 8 || rsp_illegal2 !== 1'b0) begin bad++; $display("FAIL b2b_issue_count got=%0d ill=%0b want=8 ill=0", n_iss, rsp_illegal2); end
    @(negedge clk);
    total++; if (req_ready2 !== 1'b1) begin bad++; $display("FAIL b2b_end_idle got=%0b want=1", req_ready2); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_fma();
    test_illegal();
    test_hold();
    test_midreset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
